// File: rtl/pc.sv
// Program counter register for the 8-bit CPU.
// Holds the current instruction address and loads next_pc when pc_write is high.
// The next address (pc+1, branch or jump target) is formed outside this block.
// There is no increment or wrap logic here, and pc_out comes straight from a flop.
// Optional feature macro PC_STACK_EN adds a return-address stack with call/ret.
// When the macro is undefined, the block is only the load register.
module pc #(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              STACK_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic [WIDTH-1:0] next_pc,
`ifdef PC_STACK_EN
  input  logic             call,
  input  logic             ret,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err,
`endif
  output logic [WIDTH-1:0] pc_out
);

  // The stack indexes with the low pointer bits, so the depth must be a power of 2.
  if ((STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc: STACK_DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] pc_q;

  assign pc_out = pc_q;

`ifdef PC_STACK_EN
  // The pointer counts 0..STACK_DEPTH, so it needs one bit more than the index.
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [PW-1:0]                     sp_q;
  logic [PW-1:0]                     sp_m1;
  logic [STACK_DEPTH-1:0][WIDTH-1:0] stk_q;
  logic                              err_q;
  logic                              full;
  logic                              empty;
  logic                              do_pop;
  logic                              do_push;
  logic                              do_err;
  logic [WIDTH-1:0]                  ret_addr;
  logic [AW-1:0]                     push_idx;
  logic [AW-1:0]                     top_idx;

  // Flags decode the registered pointer only, so they never glitch on inputs.
  assign full        = (sp_q == PW'(STACK_DEPTH));
  assign empty       = (sp_q == '0);
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

  assign sp_m1    = sp_q - PW'(1);
  assign push_idx = sp_q[AW-1:0];
  assign top_idx  = sp_m1[AW-1:0];
  assign ret_addr = pc_q + WIDTH'(1);

  // Resolve ret > call priority and the overflow/underflow cases.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    do_err  = 1'b0;
    if (ret) begin
      do_pop = !empty;
      do_err = empty;
    end else if (call) begin
      do_push = !full;
      do_err  = full;
    end
  end

  // PC register: a pop restores the return address, and a call jumps even on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pc_q <= RESET_VECTOR;
    else if (ret)               pc_q <= empty ? pc_q : stk_q[top_idx];
    else if (call || pc_write)  pc_q <= next_pc;
  end

  // Stack pointer and the sticky error flag; the flag clears only on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (do_pop)       sp_q <= sp_m1;
      else if (do_push) sp_q <= sp_q + PW'(1);
      if (do_err)       err_q <= 1'b1;
    end
  end

  // Return-address storage. It is cleared on reset so a pop never returns X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        stk_q <= '0;
    else if (do_push) stk_q[push_idx] <= ret_addr;
  end
`else
  // PC register: load on pc_write, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc_q <= RESET_VECTOR;
    else if (pc_write) pc_q <= next_pc;
  end
`endif

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc, with hand-computed expected values.
// The stack checks are compiled in only when PC_STACK_EN is defined.
module tb_pc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pc_write = 1'b0;
  logic [W-1:0] next_pc = '0;
  logic [W-1:0] pc_out;
`ifdef PC_STACK_EN
  logic call = 1'b0;
  logic ret = 1'b0;
  logic stack_full, stack_empty, stack_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc #(.WIDTH(W), .RESET_VECTOR(8'h00), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_write   (pc_write),
    .next_pc    (next_pc),
`ifdef PC_STACK_EN
    .call       (call),
    .ret        (ret),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err),
`endif
    .pc_out     (pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted at time zero; pc_out must be the reset vector before any edge.
    #2;
    chk("rst_during", 32'(pc_out), 32'h00);
    pc_write = 1'b1;
    next_pc  = 8'h77;
    tick();
    chk("rst_priority", 32'(pc_out), 32'h00);

    // Deassert reset; pc_write=0 means next_pc is ignored.
    @(negedge clk);
    reset    = 1'b0;
    pc_write = 1'b0;
    next_pc  = 8'h02;
    tick();
    chk("hold_after_rst", 32'(pc_out), 32'h00);
    tick();
    chk("hold_after_rst2", 32'(pc_out), 32'h00);

    // Load 1.
    @(negedge clk);
    pc_write = 1'b1;
    next_pc  = 8'h01;
    #1;
    chk("no_comb_path", 32'(pc_out), 32'h00);
    tick();
    chk("load_1", 32'(pc_out), 32'h01);

    // Load 0xA5, then hold while next_pc changes.
    @(negedge clk);
    next_pc = 8'hA5;
    tick();
    chk("load_a5", 32'(pc_out), 32'hA5);
    @(negedge clk);
    pc_write = 1'b0;
    next_pc  = 8'h3C;
    tick();
    chk("hold_a5", 32'(pc_out), 32'hA5);
    tick();
    chk("hold_a5_2", 32'(pc_out), 32'hA5);

    // Boundary values: no wrap or increment logic inside the block.
    @(negedge clk);
    pc_write = 1'b1;
    next_pc  = 8'hFF;
    tick();
    chk("load_ff", 32'(pc_out), 32'hFF);
    @(negedge clk);
    next_pc = 8'h00;
    tick();
    chk("load_00", 32'(pc_out), 32'h00);
    @(negedge clk);
    next_pc = 8'hFF;
    tick();
    chk("load_ff2", 32'(pc_out), 32'hFF);

    // Mid-cycle asynchronous reset must clear pc_out without an edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst", 32'(pc_out), 32'h00);
    tick();
    chk("async_rst_hold", 32'(pc_out), 32'h00);

    // Release reset mid-cycle; the first load happens on the next edge.
    @(negedge clk);
    reset   = 1'b0;
    next_pc = 8'h5A;
    #1;
    chk("rel_no_load", 32'(pc_out), 32'h00);
    tick();
    chk("rel_first_load", 32'(pc_out), 32'h5A);

`ifdef PC_STACK_EN
    // Reset state of the stack.
    @(negedge clk);
    reset    = 1'b1;
    pc_write = 1'b0;
    #1;
    chk("stk_rst_empty", 32'(stack_empty), 32'h1);
    chk("stk_rst_full", 32'(stack_full), 32'h0);
    chk("stk_rst_err", 32'(stack_err), 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    pc_write = 1'b1;
    next_pc  = 8'h10;
    tick();
    chk("stk_pc10", 32'(pc_out), 32'h10);

    // Call to 0x40, then return to 0x11.
    @(negedge clk);
    pc_write = 1'b0;
    call     = 1'b1;
    next_pc  = 8'h40;
    tick();
    chk("call_pc", 32'(pc_out), 32'h40);
    chk("call_nempty", 32'(stack_empty), 32'h0);
    @(negedge clk);
    call = 1'b0;
    ret  = 1'b1;
    tick();
    chk("ret_pc", 32'(pc_out), 32'h11);
    chk("ret_empty", 32'(stack_empty), 32'h1);

    // Overflow: pushes are 0x12, 0x21, 0x22, 0x23, and the fifth call only jumps.
    @(negedge clk);
    ret = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      call    = 1'b1;
      next_pc = 8'(8'h20 + i);
      tick();
      chk("ovf_err_step", 32'(stack_err), (i == 4) ? 32'h1 : 32'h0);
    end
    chk("ovf_pc", 32'(pc_out), 32'h24);
    chk("ovf_full", 32'(stack_full), 32'h1);

    // Pops return in LIFO order.
    @(negedge clk);
    call = 1'b0;
    ret  = 1'b1;
    tick();
    chk("pop1", 32'(pc_out), 32'h23);
    tick();
    chk("pop2", 32'(pc_out), 32'h22);
    tick();
    chk("pop3", 32'(pc_out), 32'h21);
    tick();
    chk("pop4", 32'(pc_out), 32'h12);
    chk("pop_empty", 32'(stack_empty), 32'h1);

    // Underflow: pc holds and the error flag stays set.
    tick();
    chk("udf_pc", 32'(pc_out), 32'h12);
    chk("udf_err", 32'(stack_err), 32'h1);

    // ret has priority over call and pc_write (stack is empty, so pc holds).
    @(negedge clk);
    call     = 1'b1;
    pc_write = 1'b1;
    next_pc  = 8'h99;
    tick();
    chk("ret_prio_pc", 32'(pc_out), 32'h12);
    chk("ret_prio_empty", 32'(stack_empty), 32'h1);

    // Only reset clears the sticky error flag.
    @(negedge clk);
    ret      = 1'b0;
    call     = 1'b0;
    pc_write = 1'b0;
    reset    = 1'b1;
    #1;
    chk("err_clear", 32'(stack_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
